// File: rtl/vmem_bridge_if.sv
// Access-unit and memory channels of vmem_bridge.
// slave = bridge side; master = access unit / memory side.
interface vmem_bridge_if;
  logic        i_write_en;
  logic [31:0] i_write_data;
  logic        i_read_en;
  logic [31:0] i_memaddr;
  logic        i_flush;
  logic        o_read_vd;
  logic [31:0] o_read_data;
  logic        o_full;
  logic        o_busy;
  logic        o_err;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_write_en, i_write_data, i_read_en, i_memaddr, i_flush,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_read_vd, o_read_data, o_full, o_busy, o_err,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_write_en, i_write_data, i_read_en, i_memaddr, i_flush,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_read_vd, o_read_data, o_full, o_busy, o_err,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/vmem_bridge.sv
// Vector memory bridge: request FIFO, in-order load return, outstanding-read tracking.
// Define VMEM_BRIDGE_RDREG_EN to register the load response (1-cycle latency).
module vmem_bridge #(
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  vmem_bridge_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic          err_q, err_d;

  logic          fifo_we_q    [DEPTH];
  logic [31:0]   fifo_addr_q  [DEPTH];
  logic [31:0]   fifo_wdata_q [DEPTH];

  logic req_any, full, empty, push, pop;
  logic head_we, issuable, mem_req, rd_grant, rsp_ok;

  assign req_any  = bus.i_write_en | bus.i_read_en;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // Flush takes priority over a same-cycle enqueue.
  assign push     = req_any & ~full & ~bus.i_flush;
  assign head_we  = fifo_we_q[rd_ptr_q];
  assign issuable = head_we | (out_q < CW'(DEPTH));
  assign mem_req  = ~empty & issuable;
  assign pop      = mem_req & bus.i_mem_gnt;
  assign rd_grant = pop & ~head_we;
  assign rsp_ok   = bus.i_mem_rvalid & (out_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    out_d    = out_q;
    err_d    = err_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    case ({rd_grant, rsp_ok})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
    if ((bus.i_write_en & bus.i_read_en) | (req_any & full) |
        (bus.i_mem_rvalid & (out_q == '0)))
      err_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (push) state_d = ACTIVE;
      ACTIVE: if (count_d == '0) state_d = (out_d != '0) ? DRAIN : IDLE;
      DRAIN: begin
        if (push)               state_d = ACTIVE;
        else if (out_d == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.i_flush) state_d = (out_d != '0) ? DRAIN : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  // A simultaneous write+read stores the write; the read is dropped.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]    <= bus.i_write_en;
      fifo_addr_q[wr_ptr_q]  <= bus.i_memaddr;
      fifo_wdata_q[wr_ptr_q] <= bus.i_write_data;
    end
  end

  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_we    = mem_req & head_we;
  assign bus.o_mem_addr  = mem_req ? fifo_addr_q[rd_ptr_q]  : '0;
  assign bus.o_mem_wdata = mem_req ? fifo_wdata_q[rd_ptr_q] : '0;
  assign bus.o_full      = full;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_err       = err_q;

`ifdef VMEM_BRIDGE_RDREG_EN
  logic        rd_vd_q;
  logic [31:0] rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vd_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vd_q   <= rsp_ok;
      rd_data_q <= rsp_ok ? bus.i_mem_rdata : '0;
    end
  end

  assign bus.o_read_vd   = rd_vd_q;
  assign bus.o_read_data = rd_data_q;
`else
  assign bus.o_read_vd   = rsp_ok;
  assign bus.o_read_data = rsp_ok ? bus.i_mem_rdata : '0;
`endif

endmodule

// File: doc/vmem_bridge.md
VMEM_BRIDGE -- requirements
Module: vmem_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4: request FIFO entries, power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_write_en, input, 1 bit: store request from the vector memory access unit.
REQ-005 SHALL have port i_write_data, input, 32 bits: store data.
REQ-006 SHALL have port i_read_en, input, 1 bit: load request.
REQ-007 SHALL have port i_memaddr, input, 32 bits: request address.
REQ-008 SHALL have port i_flush, input, 1 bit: discard queued requests.
REQ-009 SHALL have port o_read_vd, output, 1 bit: load data valid, returned to the access unit.
REQ-010 SHALL have port o_read_data, output, 32 bits: load data.
REQ-011 SHALL have port o_full, output, 1 bit: FIFO full.
REQ-012 SHALL have port o_busy, output, 1 bit: state is not IDLE.
REQ-013 SHALL have port o_err, output, 1 bit: sticky error flag.
REQ-014 SHALL have ports o_mem_req (output, 1), o_mem_we (output, 1), o_mem_addr (output, 32) and o_mem_wdata (output, 32): memory request channel.
REQ-015 SHALL have ports i_mem_gnt (input, 1), i_mem_rvalid (input, 1) and i_mem_rdata (input, 32): memory grant and response channel.

Function
REQ-016 SHALL push {we, addr, wdata} into the FIFO when (i_write_en|i_read_en) and !o_full, judged at the start of the cycle.
- A pop in the same cycle does not free a slot early.
REQ-017 SHALL enqueue a write when i_write_en and i_read_en are asserted in the same cycle, drop the read, and set o_err.
REQ-018 SHALL drop a request arriving while o_full and set o_err.
- FIFO contents are unchanged.
REQ-019 SHALL drive o_mem_req=1 with the head entry on o_mem_we/addr/wdata when the FIFO is non-empty and the head is issuable.
- A read head is issuable only if outstanding < DEPTH.
REQ-020 SHALL pop the head on the cycle o_mem_req & i_mem_gnt.
- Request fields are held stable until granted.
- Minimum enqueue-to-request latency is 1 cycle.
REQ-021 SHALL keep an outstanding-read counter, width clog2(DEPTH)+1:
- +1 on a granted read;
- -1 on i_mem_rvalid;
- unchanged when both occur in the same cycle.
REQ-022 SHALL ignore i_mem_rvalid while the counter is 0 and set o_err.
- The counter does not underflow.
REQ-023 SHALL return load responses in order: o_read_vd/o_read_data follow i_mem_rvalid/i_mem_rdata.
REQ-024 SHALL, on i_flush, clear the FIFO pointers at the next edge.
- An entry being granted in the same cycle still completes.
- Outstanding reads still return data.
REQ-025 SHALL implement states IDLE, ACTIVE and DRAIN:
- IDLE -> ACTIVE on any enqueue.
- ACTIVE -> DRAIN when the FIFO becomes empty and outstanding > 0.
- ACTIVE -> IDLE when the FIFO becomes empty and outstanding = 0.
- DRAIN -> ACTIVE on an enqueue.
- DRAIN -> IDLE when outstanding reaches 0.
- i_flush forces DRAIN, or IDLE if outstanding = 0.
REQ-026 SHALL derive o_full = (count == DEPTH).
- Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH.

Reset
REQ-027 SHALL, while rst_n = 0, asynchronously clear state to IDLE, pointers, count, the outstanding counter and o_err.
REQ-028 SHALL drive all outputs to 0 during reset, including o_mem_req.
- Responses in flight at reset are lost.
- i_mem_rvalid arriving after reset sets o_err.

Configuration
REQ-029 SHALL, when VMEM_BRIDGE_RDREG_EN is defined, register o_read_vd/o_read_data: 1-cycle response latency, registers reset to 0.
- When VMEM_BRIDGE_RDREG_EN is undefined, the path is combinational from i_mem_rvalid/i_mem_rdata with 0-cycle latency.

Verification
REQ-030 SHALL cover: write addr 0x100, data 0xDEADBEEF, i_mem_gnt tied 1 -> next cycle o_mem_req=1, we=1, addr 0x100, wdata 0xDEADBEEF; state returns to IDLE.
REQ-031 SHALL cover: 4 reads 0x200..0x20C with gnt held 0 -> o_full=1; a 5th read -> dropped, o_err=1.
REQ-032 SHALL cover: 4 reads granted, rdata 0x11/0x22/0x33/0x44 -> o_read_vd four pulses in that order; state DRAIN -> IDLE after the last pulse.
REQ-033 SHALL cover: i_write_en and i_read_en high together -> one write enqueued, o_err=1.
REQ-034 SHALL cover: 3 queued and 2 outstanding, then i_flush -> FIFO empty, state DRAIN, 2 responses delivered, then IDLE.
REQ-035 SHALL cover: rst_n low mid-DRAIN -> all outputs 0 immediately; a later i_mem_rvalid -> o_err=1, no o_read_vd pulse.
